// File: rtl/ascon_round_ctrl.sv
// ASCON permutation round controller: owns the 320-bit state register and round index,
// and sequences p12/p8/p6 through an external combinational round datapath.
module ascon_round_ctrl #(
    parameter int unsigned NB_ROUNDS_MAX = 12,
    parameter int unsigned ROUND_W       = 4
) (
    input  logic                clock_i,
    input  logic                resetb_i,
    input  logic                start_i,
    input  logic [1:0]          mode_i,
    input  logic [4:0][63:0]    init_state_i,
    input  logic [4:0][63:0]    round_state_i,
    output logic [4:0][63:0]    state_o,
    output logic [ROUND_W-1:0]  round_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NB_ROUNDS_MAX - 1);

    fsm_t               fsm;
    logic [ROUND_W-1:0] first_round;

    // Shorter permutations run the tail of the constant schedule, so they start late.
    always_comb begin
        first_round = '0;
        case (mode_i)
            2'b01:   first_round = ROUND_W'(NB_ROUNDS_MAX - 8);
            2'b10:   first_round = ROUND_W'(NB_ROUNDS_MAX - 6);
            default: first_round = '0;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm     <= IDLE;
            state_o <= '0;
            round_o <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state_o <= init_state_i;
                        round_o <= first_round;
                        busy_o  <= 1'b1;
                        fsm     <= RUN;
                    end else begin
                        busy_o  <= 1'b0;
                        fsm     <= IDLE;
                    end
                end
                RUN: begin
                    state_o <= round_state_i;
                    if (round_o == LAST_ROUND) begin
                        round_o <= '0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        fsm     <= DONE;
                    end else begin
                        round_o <= round_o + ROUND_W'(1);
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    fsm    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Self-checking bench for ascon_round_ctrl with a toy round function and a reference
// model that applies the round rule directly over the expected round schedule.
module tb_ascon_round_ctrl;

    logic             clk = 1'b0;
    logic             rstb;
    logic             start;
    logic [1:0]       mode;
    logic [4:0][63:0] init_state;
    logic [4:0][63:0] round_state;
    logic [4:0][63:0] state_o;
    logic [3:0]       round_o;
    logic             busy_o;
    logic             done_o;

    int total = 0;
    int bad   = 0;

    ascon_round_ctrl #(.NB_ROUNDS_MAX(12), .ROUND_W(4)) dut (
        .clock_i       (clk),
        .resetb_i      (rstb),
        .start_i       (start),
        .mode_i        (mode),
        .init_state_i  (init_state),
        .round_state_i (round_state),
        .state_o       (state_o),
        .round_o       (round_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    // Toy round: word0 += 1, word2[7:0] ^= round index.
    always_comb begin
        round_state          = state_o;
        round_state[0]       = state_o[0] + 64'd1;
        round_state[2][7:0]  = state_o[2][7:0] ^ {4'd0, round_o};
    end

    function automatic int unsigned nrounds(input logic [1:0] m);
        return (m == 2'b01) ? 8 : (m == 2'b10) ? 6 : 12;
    endfunction

    function automatic logic [4:0][63:0] ref_perm(input logic [4:0][63:0] init, input logic [1:0] m);
        logic [4:0][63:0] s = init;
        for (int unsigned r = 12 - nrounds(m); r < 12; r++) begin
            s[0]      = s[0] + 64'd1;
            s[2][7:0] = s[2][7:0] ^ 8'(r);
        end
        return s;
    endfunction

    function automatic logic [4:0][63:0] rand_state();
        logic [4:0][63:0] s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic test_reset();
        rstb = 1'b0; start = 1'b0; mode = 2'b00; init_state = rand_state();
        repeat (3) @(negedge clk);
        total++;
        if ({state_o, round_o, busy_o, done_o} !== '0) begin
            bad++; $display("FAIL reset: state0=%h round=%0d busy=%b done=%b, want all zero", state_o[0], round_o, busy_o, done_o);
        end
        rstb = 1'b1;
        @(negedge clk);
    endtask

    // Directed p12 / p6 / mode 11 cases followed by random ones.
    task automatic test_single();
        logic [4:0][63:0] init, exp;
        logic [1:0]       m;
        int unsigned      n;
        for (int t = 0; t < 23; t++) begin
            case (t)
                0:       begin m = 2'b00; init = '0; init[0] = 64'h10; end
                1:       begin m = 2'b10; init = '0; end
                2:       begin m = 2'b11; init = '0; init[0] = 64'h10; end
                default: begin m = 2'($urandom_range(0, 3)); init = rand_state(); end
            endcase
            n = nrounds(m);
            exp = ref_perm(init, m);
            mode = m; init_state = init; start = 1'b1;
            @(negedge clk);
            start = 1'b0; mode = 2'($urandom); init_state = rand_state();
            for (int unsigned k = 1; k <= n; k++) begin
                if (k > 1) @(negedge clk);
                total++;
                if ({busy_o, done_o, round_o} !== {1'b1, 1'b0, 4'(12 - n + k - 1)}) begin
                    bad++; $display("FAIL run t%0d k%0d: busy=%b done=%b round=%0d, want 1 0 %0d", t, k, busy_o, done_o, round_o, 12 - n + k - 1);
                end
            end
            @(negedge clk);
            total++;
            if ({busy_o, done_o, round_o} !== {1'b0, 1'b1, 4'd0} || state_o !== exp) begin
                bad++; $display("FAIL done t%0d: busy=%b done=%b round=%0d w0=%h w2=%h, want 0 1 0 w0=%h w2=%h", t, busy_o, done_o, round_o, state_o[0], state_o[2], exp[0], exp[2]);
            end
            if (t == 0 || t == 2) begin
                total++;
                if (state_o[0] !== 64'h1C) begin bad++; $display("FAIL p12 w0 t%0d: got %h want 1c", t, state_o[0]); end
            end
            if (t == 1) begin
                total++;
                if (state_o[0] !== 64'd6 || state_o[2][7:0] !== 8'h01) begin
                    bad++; $display("FAIL p6 words: w0=%h w2lo=%h want 6 01", state_o[0], state_o[2][7:0]);
                end
            end
            repeat (2) @(negedge clk);
            total++;
            if ({busy_o, done_o, round_o} !== 6'd0 || state_o !== exp) begin
                bad++; $display("FAIL idle hold t%0d: busy=%b done=%b round=%0d w0=%h want w0=%h", t, busy_o, done_o, round_o, state_o[0], exp[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0][63:0] a, b;
        logic [5:0]       want;
        a = rand_state(); b = rand_state();
        mode = 2'b01; init_state = a; start = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 1)  begin mode = 2'b10; init_state = b; end
            if (k == 10) begin start = 1'b0; init_state = rand_state(); end
            if (k <= 8)       want = {1'b1, 1'b0, 4'(4 + k - 1)};
            else if (k == 9)  want = {1'b0, 1'b1, 4'd0};
            else if (k <= 15) want = {1'b1, 1'b0, 4'(6 + k - 10)};
            else if (k == 16) want = {1'b0, 1'b1, 4'd0};
            else              want = 6'd0;
            total++;
            if ({busy_o, done_o, round_o} !== want) begin
                bad++; $display("FAIL b2b k%0d: busy/done/round=%b want %b", k, {busy_o, done_o, round_o}, want);
            end
            if (k == 9 || k == 16) begin
                total++;
                if (state_o !== ((k == 9) ? ref_perm(a, 2'b01) : ref_perm(b, 2'b10))) begin
                    bad++; $display("FAIL b2b result k%0d: w0=%h w2=%h", k, state_o[0], state_o[2]);
                end
            end
        end
    endtask

    task automatic test_run_ignore();
        logic [4:0][63:0] a;
        logic [5:0]       want;
        a = rand_state();
        mode = 2'b00; init_state = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 3) start = 1'b1;
            if (k == 4) start = 1'b0;
            if (k == 5) mode = 2'b10;
            want = (k <= 12) ? {1'b1, 1'b0, 4'(k - 1)} : (k == 13) ? 6'b010000 : 6'd0;
            total++;
            if ({busy_o, done_o, round_o} !== want) begin
                bad++; $display("FAIL ignore k%0d: busy/done/round=%b want %b", k, {busy_o, done_o, round_o}, want);
            end
        end
        total++;
        if (state_o !== ref_perm(a, 2'b00)) begin
            bad++; $display("FAIL ignore result: w0=%h want %h", state_o[0], ref_perm(a, 2'b00));
        end
    endtask

    task automatic test_async_reset();
        logic [4:0][63:0] a;
        logic             saw_done = 1'b0;
        a = rand_state(); a[0] = a[0] | 64'h1;
        mode = 2'b00; init_state = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (round_o !== 4'd5 || busy_o !== 1'b1) begin
            bad++; $display("FAIL pre-abort: round=%0d busy=%b want 5 1", round_o, busy_o);
        end
        #2 rstb = 1'b0;
        #1;
        total++;
        if ({state_o, round_o, busy_o, done_o} !== '0) begin
            bad++; $display("FAIL abort: w0=%h round=%0d busy=%b done=%b want all zero", state_o[0], round_o, busy_o, done_o);
        end
        repeat (3) begin @(negedge clk); saw_done |= done_o | busy_o; end
        rstb = 1'b1;
        repeat (3) begin @(negedge clk); saw_done |= done_o | busy_o; end
        total++;
        if (saw_done !== 1'b0) begin bad++; $display("FAIL abort activity: saw busy/done=%b want 0", saw_done); end
        a = rand_state();
        init_state = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || state_o !== ref_perm(a, 2'b00)) begin
            bad++; $display("FAIL post-abort run: done=%b busy=%b w0=%h want 1 0 %h", done_o, busy_o, state_o[0], ref_perm(a, 2'b00));
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_run_ignore();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascon_round_ctrl.md
Name: ascon_round_ctrl

Overview:
- Sequential driver for the ASCON permutation datapath: constant addition, then substitution, then linear layer.
- Holds the 320-bit permutation state register and the round counter.
- Both feed the constant-addition stage directly: state_o goes to its state input, round_o to its round index.
- The combinational round result comes back on round_state_i and is registered each cycle; a start/done handshake runs p12, p8 or p6.

Parameters:
- NB_ROUNDS_MAX, 12, total round constants; the last round index is NB_ROUNDS_MAX-1.
- ROUND_W, 4, width of the round index.

Ports:
- clock_i  input  1  system clock, rising edge.
- resetb_i  input  1  asynchronous active-low reset.
- start_i  input  1  request a permutation; sampled in IDLE and DONE only.
- mode_i  input  2  round count select: 00 = p12, 01 = p8, 10 = p6, 11 = p12. Sampled with start_i.
- init_state_i  input  type_state (5x64)  state loaded on accepted start.
- round_state_i  input  type_state  combinational round output computed from state_o and round_o.
- state_o  output  type_state  current state register, to the constant-addition stage.
- round_o  output  ROUND_W  current round index, to the constant-addition stage.
- busy_o  output  1  high while rounds are executing.
- done_o  output  1  one-cycle pulse; state_o holds the final permutation result.

Behaviour:
- Reset (resetb_i low, any time, asynchronous): FSM goes to IDLE; state register = 0; round counter = 0; busy_o = 0; done_o = 0.
- Reset mid-RUN aborts the permutation; there is no resumption.
- FSM states: IDLE, RUN, DONE.
- IDLE, start_i = 1:
  - state register <= init_state_i.
  - round counter <= first index: 0 for p12, 4 for p8, 6 for p6.
  - Go to RUN.
- IDLE, start_i = 0: hold everything; round_o = 0.
- RUN, every cycle:
  - state register <= round_state_i.
  - If counter == NB_ROUNDS_MAX-1: counter <= 0, go to DONE.
  - Else: counter <= counter + 1.
- RUN ignores start_i and any mode_i change.
- DONE lasts exactly one cycle:
  - done_o = 1, busy_o = 0.
  - state_o holds the result; the state register is not written.
  - start_i = 1: accepted exactly as in IDLE, go to RUN (back-to-back permutations allowed).
  - start_i = 0: go to IDLE.
- busy_o = 1 exactly in RUN. done_o = 1 exactly in DONE. Both are registered (Moore), never high together.
- Latency: start accepted at edge N means busy_o is high for cycles N+1 .. N+R, and done_o is high in cycle N+R+1.
  - R = 12 / 8 / 6 for p12 / p8 / p6.
  - The state register is updated R times.
- state_o is stable from DONE until the next accepted start, including while in IDLE.
- round_o sequences:
  - p12: 0..11.
  - p8: 4..11.
  - p6: 6..11.
  - The counter never exceeds NB_ROUNDS_MAX-1; no wrap past 11.
- mode_i = 11 behaves identically to 00.
- start_i held high continuously gives back-to-back permutations with one DONE cycle between them.

Test Plan:
- Bench round model: round_state_i = state_o with word0 += 1 and word2[7:0] ^= round_o.
- Reset then p12: init word0 = 0x10, start pulse.
  - Expect round_o = 0..11 over 12 busy cycles, then done_o one cycle.
  - Expect word0 = 0x1C at done and busy_o = 0 at done.
- p6: mode_i = 10, init word0 = 0.
  - Expect round_o = 6..11 over 6 busy cycles.
  - Expect word0 = 6 at done and word2[7:0] = 6^7^8^9^10^11 = 0x01.
- p8 then immediate p6: start_i held high through DONE.
  - Expect done_o at cycle 9 and 16 after the first start.
  - Expect the second load taken from init_state_i in the DONE cycle.
- start_i pulsed during RUN, with mode_i changed to 10 in the middle of a p12.
  - Expect no effect: 12 rounds still complete; done_o at cycle 13.
- Asynchronous reset asserted at round 5 of p12.
  - Expect state_o = 0, round_o = 0, busy_o = 0 immediately, with no done_o.
  - Next start runs a full 12 rounds.
- mode_i = 11: expect identical timing and result to p12.
